// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit single-cycle CPU: datapath widths and ALU opcodes.
package cpu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_COUNT  = 8;
    localparam int REG_ADDR_W = 3;
    localparam int ALU_OP_W   = 3;

    localparam logic [ALU_OP_W-1:0] ALU_FWD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;

endpackage

// File: rtl/regfile_alu_core_if.sv
// Bus between control/operand-select logic (master) and the register-file/ALU core (slave).
interface regfile_alu_core_if;
    import cpu_pkg::*;

    logic [DATA_W-1:0]     WRITEDATA;
    logic [REG_ADDR_W-1:0] WRITEREG;
    logic                  WRITEENABLE;
    logic [REG_ADDR_W-1:0] READREG1;
    logic [REG_ADDR_W-1:0] READREG2;
    logic [DATA_W-1:0]     OPERAND2;
    logic [ALU_OP_W-1:0]   ALUOP;
    logic [DATA_W-1:0]     REGOUT1;
    logic [DATA_W-1:0]     REGOUT2;
    logic [DATA_W-1:0]     ALURESULT;
    logic                  ZERO;

    modport master (
        output WRITEDATA, WRITEREG, WRITEENABLE, READREG1, READREG2, OPERAND2, ALUOP,
        input  REGOUT1, REGOUT2, ALURESULT, ZERO
    );

    modport slave (
        input  WRITEDATA, WRITEREG, WRITEENABLE, READREG1, READREG2, OPERAND2, ALUOP,
        output REGOUT1, REGOUT2, ALURESULT, ZERO
    );

endinterface

// File: rtl/regfile_alu_core_alu.sv
// Combinational 8-bit ALU: forward, add (mod 256), and, or; reserved opcodes yield 0x00.
// REGFILE_ALU_SIM_DELAY_EN adds simulation-only result delays (#1 logic/forward, #2 add).
module core_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0]   op1,
    input  logic [DATA_W-1:0]   op2,
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic [DATA_W-1:0]   result,
    output logic                zero
);

    logic [DATA_W-1:0] fwd_res;
    logic [DATA_W-1:0] add_res;
    logic [DATA_W-1:0] and_res;
    logic [DATA_W-1:0] or_res;

`ifdef REGFILE_ALU_SIM_DELAY_EN
    assign #1 fwd_res = op2;
    assign #2 add_res = op1 + op2;
    assign #1 and_res = op1 & op2;
    assign #1 or_res  = op1 | op2;
`else
    assign fwd_res = op2;
    assign add_res = op1 + op2;
    assign and_res = op1 & op2;
    assign or_res  = op1 | op2;
`endif

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_FWD: result = fwd_res;
            ALU_ADD: result = add_res;
            ALU_AND: result = and_res;
            ALU_OR:  result = or_res;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/regfile_alu_core.sv
// Execution core: 8x8 register file (two combinational reads, one clocked write) feeding core_alu.
// REGFILE_ALU_SIM_DELAY_EN adds simulation-only delays on reads (#2), writes (#1) and reset clear (#1).
module regfile_alu_core
    import cpu_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET_N,
    regfile_alu_core_if.slave bus
);

    logic [REG_COUNT-1:0][DATA_W-1:0] reg_file;

    // One flop bank per register so the asynchronous clear hits all of them at once.
    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            localparam logic [REG_ADDR_W-1:0] REG_IDX = REG_ADDR_W'(gi);
            logic [DATA_W-1:0] data_reg;

            always_ff @(posedge CLK or negedge RESET_N) begin
`ifdef REGFILE_ALU_SIM_DELAY_EN
                if (!RESET_N)
                    data_reg <= #1 '0;
                else if (bus.WRITEENABLE && (bus.WRITEREG == REG_IDX))
                    data_reg <= #1 bus.WRITEDATA;
`else
                if (!RESET_N)
                    data_reg <= '0;
                else if (bus.WRITEENABLE && (bus.WRITEREG == REG_IDX))
                    data_reg <= bus.WRITEDATA;
`endif
            end

            assign reg_file[gi] = data_reg;
        end
    endgenerate

    // No write-through bypass: a read of the register being written shows the old value until the edge.
`ifdef REGFILE_ALU_SIM_DELAY_EN
    assign #2 bus.REGOUT1 = reg_file[bus.READREG1];
    assign #2 bus.REGOUT2 = reg_file[bus.READREG2];
`else
    assign bus.REGOUT1 = reg_file[bus.READREG1];
    assign bus.REGOUT2 = reg_file[bus.READREG2];
`endif

    core_alu u_alu (
        .op1    (bus.REGOUT1),
        .op2    (bus.OPERAND2),
        .alu_op (bus.ALUOP),
        .result (bus.ALURESULT),
        .zero   (bus.ZERO)
    );

endmodule

// File: tb/tb_regfile_alu_core.sv
// Directed self-checking bench for regfile_alu_core: reset, read/write, ALU ops, write timing, wrap-around.
module tb_regfile_alu_core;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    regfile_alu_core_if bus ();

    regfile_alu_core dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.WRITEENABLE = 1'b1;
        bus.WRITEREG    = addr;
        bus.WRITEDATA   = data;
        @(negedge clk);
        bus.WRITEENABLE = 1'b0;
        $display("write r%0d <= 0x%02h", addr, data);
    endtask

    task automatic test_reset();
        logic [7:0] exp_val;
        // Power-up reset: outputs read zero without any clock edge.
        bus.READREG1 = 3'd0;
        bus.READREG2 = 3'd7;
        #1;
        total++;
        if (bus.REGOUT1 !== 8'h00 || bus.REGOUT2 !== 8'h00)
            $display("FAIL reset_initial: regout1=0x%02h regout2=0x%02h required 0x00/0x00", bus.REGOUT1, bus.REGOUT2);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < REG_COUNT; i++) begin
            exp_val = 8'(8'h11 * (i + 1));
            write_reg(3'(i), exp_val);
        end
        bus.READREG1 = 3'd6;
        #1;
        total++;
        if (bus.REGOUT1 !== 8'h77)
            $display("FAIL reset_prewrite: r6=0x%02h required 0x77", bus.REGOUT1);
        else passed++;

        // Assert reset mid-cycle; registers must clear with no edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            bus.READREG1 = 3'(i);
            bus.READREG2 = 3'(REG_COUNT - 1 - i);
            #1;
            total++;
            if (bus.REGOUT1 !== 8'h00 || bus.REGOUT2 !== 8'h00)
                $display("FAIL reset_clear r%0d: regout1=0x%02h regout2=0x%02h required 0x00", i, bus.REGOUT1, bus.REGOUT2);
            else passed++;
        end

        // Write while reset held must be ignored.
        bus.READREG1    = 3'd5;
        bus.WRITEENABLE = 1'b1;
        bus.WRITEREG    = 3'd5;
        bus.WRITEDATA   = 8'h77;
        @(posedge clk);
        #1;
        total++;
        if (bus.REGOUT1 !== 8'h00)
            $display("FAIL reset_write_ignored: r5=0x%02h required 0x00", bus.REGOUT1);
        else passed++;
        @(negedge clk);
        bus.WRITEENABLE = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_read_write();
        write_reg(3'd1, 8'h05);
        write_reg(3'd2, 8'h03);
        bus.READREG1 = 3'd1;
        bus.READREG2 = 3'd2;
        #1;
        total++;
        if (bus.REGOUT1 !== 8'h05 || bus.REGOUT2 !== 8'h03)
            $display("FAIL read_ports: regout1=0x%02h regout2=0x%02h required 0x05/0x03", bus.REGOUT1, bus.REGOUT2);
        else passed++;

        // Same address on both ports.
        bus.READREG2 = 3'd1;
        #1;
        total++;
        if (bus.REGOUT2 !== 8'h05)
            $display("FAIL read_same_addr: regout2=0x%02h required 0x05", bus.REGOUT2);
        else passed++;

        // WRITEENABLE low over an edge: no change.
        bus.READREG2    = 3'd2;
        bus.WRITEENABLE = 1'b0;
        bus.WRITEREG    = 3'd1;
        bus.WRITEDATA   = 8'hEE;
        @(posedge clk);
        #1;
        total++;
        if (bus.REGOUT1 !== 8'h05 || bus.REGOUT2 !== 8'h03)
            $display("FAIL write_disabled: regout1=0x%02h regout2=0x%02h required 0x05/0x03", bus.REGOUT1, bus.REGOUT2);
        else passed++;
    endtask

    task automatic test_add();
        bus.READREG1 = 3'd1;
        bus.ALUOP    = ALU_ADD;
        bus.OPERAND2 = 8'hFD;
        #1;
        total++;
        if (bus.ALURESULT !== 8'h02 || bus.ZERO !== 1'b0)
            $display("FAIL add_sub3: result=0x%02h zero=%0b required 0x02/0", bus.ALURESULT, bus.ZERO);
        else passed++;
        bus.OPERAND2 = 8'hFB;
        #1;
        total++;
        if (bus.ALURESULT !== 8'h00 || bus.ZERO !== 1'b1)
            $display("FAIL add_beq_equal: result=0x%02h zero=%0b required 0x00/1", bus.ALURESULT, bus.ZERO);
        else passed++;
    endtask

    task automatic test_logic();
        write_reg(3'd1, 8'hCC);
        bus.READREG1 = 3'd1;
        bus.OPERAND2 = 8'hAA;
        bus.ALUOP    = ALU_AND;
        #1;
        total++;
        if (bus.ALURESULT !== 8'h88 || bus.ZERO !== 1'b0)
            $display("FAIL alu_and: result=0x%02h zero=%0b required 0x88/0", bus.ALURESULT, bus.ZERO);
        else passed++;
        bus.ALUOP = ALU_OR;
        #1;
        total++;
        if (bus.ALURESULT !== 8'hEE || bus.ZERO !== 1'b0)
            $display("FAIL alu_or: result=0x%02h zero=%0b required 0xEE/0", bus.ALURESULT, bus.ZERO);
        else passed++;
        bus.ALUOP = ALU_FWD;
        #1;
        total++;
        if (bus.ALURESULT !== 8'hAA || bus.ZERO !== 1'b0)
            $display("FAIL alu_fwd: result=0x%02h zero=%0b required 0xAA/0", bus.ALURESULT, bus.ZERO);
        else passed++;
        bus.OPERAND2 = 8'h00;
        #1;
        total++;
        if (bus.ALURESULT !== 8'h00 || bus.ZERO !== 1'b1)
            $display("FAIL alu_fwd_zero: result=0x%02h zero=%0b required 0x00/1", bus.ALURESULT, bus.ZERO);
        else passed++;
        bus.OPERAND2 = 8'hAA;
        bus.ALUOP    = 3'b101;
        #1;
        total++;
        if (bus.ALURESULT !== 8'h00 || bus.ZERO !== 1'b1)
            $display("FAIL alu_reserved_101: result=0x%02h zero=%0b required 0x00/1", bus.ALURESULT, bus.ZERO);
        else passed++;
        bus.ALUOP = 3'b111;
        #1;
        total++;
        if (bus.ALURESULT !== 8'h00 || bus.ZERO !== 1'b1)
            $display("FAIL alu_reserved_111: result=0x%02h zero=%0b required 0x00/1", bus.ALURESULT, bus.ZERO);
        else passed++;
    endtask

    task automatic test_back_to_back();
        write_reg(3'd3, 8'h10);
        bus.READREG1 = 3'd3;
        @(negedge clk);
        bus.WRITEENABLE = 1'b1;
        bus.WRITEREG    = 3'd3;
        bus.WRITEDATA   = 8'h20;
        #1;
        total++;
        if (bus.REGOUT1 !== 8'h10)
            $display("FAIL write_before_edge: r3=0x%02h required 0x10", bus.REGOUT1);
        else passed++;
        @(posedge clk);
        #1;
        bus.WRITEENABLE = 1'b0;
        total++;
        if (bus.REGOUT1 !== 8'h20)
            $display("FAIL write_after_edge: r3=0x%02h required 0x20", bus.REGOUT1);
        else passed++;
        $display("write r3 <= 0x20 (timing)");
    endtask

    task automatic test_wrap();
        write_reg(3'd4, 8'hFF);
        bus.READREG1 = 3'd4;
        bus.OPERAND2 = 8'h01;
        bus.ALUOP    = ALU_ADD;
        #1;
        total++;
        if (bus.ALURESULT !== 8'h00 || bus.ZERO !== 1'b1)
            $display("FAIL add_wrap: result=0x%02h zero=%0b required 0x00/1", bus.ALURESULT, bus.ZERO);
        else passed++;
        // Other registers untouched by this sequence.
        bus.READREG2 = 3'd2;
        #1;
        total++;
        if (bus.REGOUT2 !== 8'h03)
            $display("FAIL r2_retained: r2=0x%02h required 0x03", bus.REGOUT2);
        else passed++;
    endtask

    initial begin
        passed          = 0;
        total           = 0;
        rst_n           = 1'b1;
        bus.WRITEDATA   = 8'h00;
        bus.WRITEREG    = 3'd0;
        bus.WRITEENABLE = 1'b0;
        bus.READREG1    = 3'd0;
        bus.READREG2    = 3'd0;
        bus.OPERAND2    = 8'h00;
        bus.ALUOP       = ALU_FWD;
        #1 rst_n = 1'b0;

        test_reset();
        test_read_write();
        test_add();
        test_logic();
        test_back_to_back();
        test_wrap();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
